// File: rtl/io_poll_master_if.sv
// Bus and stream bundle between the I/O poll master and its neighbours:
// the switch/LED peripheral bus, the switch-word output stream and the LED
// input stream.
interface io_poll_master_if;
  logic        io_read;
  logic        io_write;
  logic [1:0]  io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        sw_valid;
  logic        sw_ready;
  logic [15:0] sw_data;
  logic        led_valid;
  logic        led_ready;
  logic [11:0] led_data;

  modport master (
    output io_read, io_write, io_addr, io_wdata, sw_valid, sw_data, led_ready,
    input  io_rdata, sw_ready, led_valid, led_data
  );

  modport slave (
    input  io_read, io_write, io_addr, io_wdata, sw_valid, sw_data, led_ready,
    output io_rdata, sw_ready, led_valid, led_data
  );
endinterface

// File: rtl/io_poll_master.sv
// I/O poll master: periodically reads the peripheral status word and, when
// new input is flagged, fetches the 16-bit switch value as two byte reads
// and offers it on a valid/ready stream. LED words from a producer stream
// are written to the LED register, with priority over polling. All bus
// outputs are decoded from the state register only.
module io_poll_master #(
  parameter int POLL_INTERVAL  = 16,
  parameter bit ONLY_ON_CHANGE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  io_poll_master_if.master  bus,
  output logic              busy
);

  localparam int CW = $clog2(POLL_INTERVAL);
  localparam logic [CW-1:0] CNT_MAX = CW'(POLL_INTERVAL - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_LED, S_RD_STAT, S_CAP_STAT, S_RD_LO, S_CAP_LO,
    S_RD_HI, S_CAP_HI, S_EMIT
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   poll_cnt;
  logic [7:0]      lo_byte;
  logic [15:0]     sw_word;
  logic [15:0]     last_word;
  logic            have_last;
  logic [15:0]     assembled;
  logic            poll_due;
  logic            suppress;
  logic            unused_rdata;

  assign assembled    = {bus.io_rdata[7:0], lo_byte};
  assign poll_due     = (poll_cnt == CNT_MAX);
  assign suppress     = ONLY_ON_CHANGE && have_last && (assembled == last_word);
  assign unused_rdata = ^bus.io_rdata[31:8];

  // State register; reset aborts any bus sequence at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state: LED writes win over polling; status bit 1 flags new input.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.led_valid)  state_nxt = S_WR_LED;
        else if (poll_due)  state_nxt = S_RD_STAT;
      end
      S_WR_LED:   state_nxt = S_IDLE;
      S_RD_STAT:  state_nxt = S_CAP_STAT;
      S_CAP_STAT: state_nxt = bus.io_rdata[1] ? S_RD_LO : S_IDLE;
      S_RD_LO:    state_nxt = S_CAP_LO;
      S_CAP_LO:   state_nxt = S_RD_HI;
      S_RD_HI:    state_nxt = S_CAP_HI;
      S_CAP_HI:   state_nxt = suppress ? S_IDLE : S_EMIT;
      S_EMIT:     state_nxt = bus.sw_ready ? S_IDLE : S_EMIT;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Moore output decode: at most one strobe per state, address idles at 00.
  always_comb begin
    bus.io_read   = 1'b0;
    bus.io_write  = 1'b0;
    bus.io_addr   = 2'b00;
    bus.io_wdata  = 32'd0;
    bus.led_ready = 1'b0;
    bus.sw_valid  = 1'b0;
    case (state)
      S_WR_LED: begin
        bus.io_write  = 1'b1;
        bus.io_addr   = 2'b01;
        bus.io_wdata  = {20'd0, bus.led_data};
        bus.led_ready = 1'b1;
      end
      S_RD_STAT: bus.io_read = 1'b1;
      S_RD_LO: begin
        bus.io_read = 1'b1;
        bus.io_addr = 2'b10;
      end
      S_RD_HI: begin
        bus.io_read = 1'b1;
        bus.io_addr = 2'b11;
      end
      S_EMIT:  bus.sw_valid = 1'b1;
      default: ;
    endcase
  end

  assign busy        = (state != S_IDLE);
  assign bus.sw_data = sw_word;

  // Poll counter: only advances in IDLE, saturates, clears when a poll starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      poll_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (!bus.led_valid && poll_due) poll_cnt <= '0;
      else if (!poll_due)             poll_cnt <= poll_cnt + 1'b1;
    end
  end

  // Low switch byte holding register; only meaningful once CAP_LO has run.
  always_ff @(posedge clk) begin
    if (state == S_CAP_LO) lo_byte <= bus.io_rdata[7:0];
  end

  // Assembled word and last-emitted tracking for change suppression.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_word   <= 16'd0;
      last_word <= 16'd0;
      have_last <= 1'b0;
    end else begin
      if (state == S_CAP_HI) sw_word <= assembled;
      if (state == S_EMIT && bus.sw_ready) begin
        last_word <= sw_word;
        have_last <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_io_poll_master.sv
// Bench for io_poll_master: peripheral model, operation-queue reference
// model with a per-cycle output compare, directed scenarios with literal
// expectations, then randomized traffic including a mid-run reset.
module tb_io_poll_master;
  localparam int PI  = 16;
  localparam bit OOC = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;

  io_poll_master_if bus();

  io_poll_master #(.POLL_INTERVAL(PI), .ONLY_ON_CHANGE(OOC)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Peripheral registers and bus model (read data registered, junk in unused bits)
  logic [1:0]  stat_reg = 2'd0;
  logic [15:0] sw_reg   = 16'd0;
  logic [31:0] led_reg  = 32'd0;

  function automatic logic [31:0] rd_val(input logic [1:0] a, input logic [31:0] junk);
    case (a)
      2'd0:    return {junk[31:2], stat_reg};
      2'd1:    return led_reg;
      2'd2:    return {junk[31:8], sw_reg[7:0]};
      default: return {junk[31:8], sw_reg[15:8]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.io_read) bus.io_rdata <= rd_val(bus.io_addr, $urandom());
    if (bus.io_write && bus.io_addr == 2'b01) led_reg <= bus.io_wdata;
  end

  // Reference model: a queue of planned per-cycle bus operations
  typedef enum {OP_RD, OP_CAP, OP_WR, OP_EMIT} op_e;
  typedef struct {
    op_e         kind;
    logic [1:0]  addr;
    logic [31:0] data;
  } op_t;

  op_t         plan[$];
  int          m_cnt  = 0;
  bit          m_have = 1'b0;
  logic [15:0] m_last = 16'd0;
  logic [7:0]  m_lo   = 8'd0;
  logic [31:0] m_rdv  = 32'd0;

  function automatic op_t mk(input op_e k, input logic [1:0] a, input logic [31:0] d);
    op_t o;
    o.kind = k;
    o.addr = a;
    o.data = d;
    return o;
  endfunction

  initial begin
    op_t         o;
    bit          poll;
    logic [15:0] word;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        plan.delete();
        m_cnt  = 0;
        m_have = 1'b0;
        m_last = 16'd0;
      end else if (plan.size() == 0) begin
        poll = (m_cnt == PI - 1);
        if (m_cnt < PI - 1) m_cnt++;
        if (bus.led_valid) begin
          plan.push_back(mk(OP_WR, 2'd1, {20'd0, bus.led_data}));
        end else if (poll) begin
          plan.push_back(mk(OP_RD, 2'd0, 32'd0));
          plan.push_back(mk(OP_CAP, 2'd0, 32'd0));
          m_cnt = 0;
        end
      end else begin
        o = plan[0];
        case (o.kind)
          OP_RD: begin
            m_rdv = rd_val(o.addr, 32'd0);
            void'(plan.pop_front());
          end
          OP_CAP: begin
            void'(plan.pop_front());
            if (o.addr == 2'd0) begin
              if (m_rdv[1]) begin
                plan.push_back(mk(OP_RD, 2'd2, 32'd0));
                plan.push_back(mk(OP_CAP, 2'd2, 32'd0));
              end
            end else if (o.addr == 2'd2) begin
              m_lo = m_rdv[7:0];
              plan.push_back(mk(OP_RD, 2'd3, 32'd0));
              plan.push_back(mk(OP_CAP, 2'd3, 32'd0));
            end else begin
              word = {m_rdv[7:0], m_lo};
              if (!(OOC && m_have && word == m_last))
                plan.push_back(mk(OP_EMIT, 2'd0, {16'd0, word}));
            end
          end
          OP_WR: void'(plan.pop_front());
          default: begin
            if (bus.sw_ready) begin
              m_last = o.data[15:0];
              m_have = 1'b1;
              void'(plan.pop_front());
            end
          end
        endcase
      end
    end
  end

  // Event logs used by the directed scenarios
  int  rd_addr_q[$], rd_cyc_q[$], emit_cyc_q[$], acc_q[$], acc_cyc_q[$], wr_q[$], wr_cyc_q[$];
  logic prev_valid = 1'b0;

  task automatic clear_logs();
    rd_addr_q.delete(); rd_cyc_q.delete(); emit_cyc_q.delete();
    acc_q.delete(); acc_cyc_q.delete(); wr_q.delete(); wr_cyc_q.delete();
  endtask

  // Per-cycle compare against the model, plus event logging
  initial begin
    logic        e_rd, e_wr, e_vld, e_lrdy, e_busy;
    logic [1:0]  e_addr;
    logic [31:0] e_wdata;
    logic [15:0] e_data;
    logic [54:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      e_rd = 0; e_wr = 0; e_vld = 0; e_lrdy = 0; e_busy = 0;
      e_addr = 0; e_wdata = 0; e_data = 0;
      if (plan.size() != 0) begin
        e_busy = 1;
        case (plan[0].kind)
          OP_RD:  begin e_rd = 1; e_addr = plan[0].addr; end
          OP_WR:  begin e_wr = 1; e_addr = 2'd1; e_wdata = plan[0].data; e_lrdy = 1; end
          OP_EMIT: begin e_vld = 1; e_data = plan[0].data[15:0]; end
          default: ;
        endcase
      end
      exp_v = {e_rd, e_wr, e_addr, e_wdata, e_vld, e_data, e_lrdy, e_busy};
      act_v = {bus.io_read, bus.io_write,
               (bus.io_read | bus.io_write) ? bus.io_addr : 2'd0,
               bus.io_wdata, bus.sw_valid,
               bus.sw_valid ? bus.sw_data : 16'd0,
               bus.led_ready, busy};
      check("cycle outputs", {9'd0, act_v}, {9'd0, exp_v});
      if (bus.io_read) begin rd_addr_q.push_back(int'(bus.io_addr)); rd_cyc_q.push_back(cyc); end
      if (bus.io_write) begin wr_q.push_back(int'(bus.io_wdata)); wr_cyc_q.push_back(cyc); end
      if (bus.sw_valid && !prev_valid) emit_cyc_q.push_back(cyc);
      if (bus.sw_valid && bus.sw_ready) begin acc_q.push_back(int'(bus.sw_data)); acc_cyc_q.push_back(cyc); end
      prev_valid = bus.sw_valid;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_poll();
    bit found = 1'b0;
    clear_logs();
    for (int i = 0; i < 60 && !found; i++) begin
      wait_cycles(1);
      if (rd_addr_q.size() > 0) found = 1'b1;
    end
    check("poll started", found, 1'b1);
    wait_cycles(12);
  endtask

  task automatic wait_led_ready();
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bus.led_ready) found = 1'b1;
    end
    check("led_ready seen", found, 1'b1);
    @(posedge clk); #1;
    bus.led_valid = 1'b0;
  endtask

  initial begin
    int c0, c_led;
    bit found, ledhs;
    bus.led_valid = 1'b0;
    bus.led_data  = 12'd0;
    bus.sw_ready  = 1'b1;
    wait_cycles(3);

    // Reset state
    check("reset sw_data", bus.sw_data, 16'd0);
    check("reset strobes/busy", {bus.io_read, bus.io_write, bus.io_addr, bus.sw_valid, bus.led_ready, busy}, 7'd0);

    // 1: first poll PI cycles after release, reads 00,10,11, 6-cycle latency
    stat_reg = 2'd2;
    sw_reg   = 16'hA55A;
    clear_logs();
    rst = 1'b1;
    c0  = cyc;
    wait_cycles(30);
    check("t1 first poll delay", qget(rd_cyc_q, 0) - c0, PI);
    check("t1 read count", rd_addr_q.size(), 3);
    check("t1 read order", {qget(rd_addr_q, 0), qget(rd_addr_q, 1), qget(rd_addr_q, 2)}, {32'd0, 32'd2, 32'd3});
    check("t1 sw_valid latency", qget(emit_cyc_q, 0) - qget(rd_cyc_q, 0), 6);
    check("t1 sw_data", qget(acc_q, 0), 32'hA55A);

    // 2: same value suppressed, new value emitted
    run_poll();
    check("t2 full reads when unchanged", rd_addr_q.size(), 3);
    check("t2 suppressed", emit_cyc_q.size(), 0);
    sw_reg = 16'h1234;
    run_poll();
    check("t2 new value", qget(acc_q, 0), 32'h1234);

    // 3: no new input -> single status read, next poll after PI idle cycles
    stat_reg = 2'd1;
    run_poll();
    check("t3 single read", rd_addr_q.size(), 1);
    wait_cycles(10);
    check("t3 poll spacing", qget(rd_cyc_q, 1) - qget(rd_cyc_q, 0), PI + 2);

    // 4: LED write from IDLE
    clear_logs();
    bus.led_valid = 1'b1;
    bus.led_data  = 12'hABC;
    c_led = cyc;
    wait_led_ready();
    check("t4 write count", wr_q.size(), 1);
    check("t4 io_wdata", qget(wr_q, 0), 32'h00000ABC);
    check("t4 write latency", qget(wr_cyc_q, 0) - c_led, 1);
    check("t4 led register", led_reg, 32'h00000ABC);

    // 5: stalled EMIT holds data, LED write waits for handshake
    stat_reg = 2'd2;
    sw_reg   = 16'h5A5A;
    bus.sw_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bus.sw_valid) found = 1'b1;
    end
    check("t5 reached EMIT", found, 1'b1);
    @(posedge clk); #1;
    bus.led_valid = 1'b1;
    bus.led_data  = 12'h123;
    repeat (10) begin
      @(negedge clk);
      check("t5 hold", {bus.sw_valid, bus.sw_data, bus.io_write, bus.led_ready}, {1'b1, 16'h5A5A, 1'b0, 1'b0});
    end
    @(posedge clk); #1;
    clear_logs();
    bus.sw_ready = 1'b1;
    wait_led_ready();
    wait_cycles(2);
    check("t5 accepted", qget(acc_q, 0), 32'h5A5A);
    check("t5 write after handshake", qget(wr_cyc_q, 0) - qget(acc_cyc_q, 0), 2);
    check("t5 io_wdata", qget(wr_q, 0), 32'h00000123);

    // 6: reset during CAP_LO
    sw_reg = 16'h7777;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bus.io_read && bus.io_addr == 2'b10) found = 1'b1;
    end
    check("t6 reached RD_LO", found, 1'b1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("t6 outputs at reset", {bus.io_read, bus.io_write, bus.io_addr, bus.io_wdata, bus.sw_valid, bus.sw_data, bus.led_ready, busy}, 55'd0);
    wait_cycles(2);
    sw_reg = 16'h5A5A;
    clear_logs();
    rst = 1'b1;
    c0  = cyc;
    wait_cycles(30);
    check("t6 first poll delay", qget(rd_cyc_q, 0) - c0, PI);
    check("t6 have_last cleared", qget(acc_q, 0), 32'h5A5A);

    // Randomized traffic with one asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ledhs = bus.led_valid && bus.led_ready;
      @(posedge clk);
      if (i == 1500) begin
        #2 rst = 1'b0;
        wait_cycles(3);
        rst = 1'b1;
      end else begin
        #1;
      end
      if (ledhs) bus.led_valid = 1'b0;
      else if (!bus.led_valid && ($urandom % 16 == 0)) begin
        bus.led_valid = 1'b1;
        bus.led_data  = 12'($urandom);
      end
      bus.sw_ready = ($urandom % 3 != 0);
      if ($urandom % 6 == 0) begin
        stat_reg = 2'($urandom);
        case ($urandom % 4)
          0: sw_reg = 16'hA55A;
          1: sw_reg = 16'h1234;
          2: sw_reg = sw_reg;
          default: sw_reg = 16'($urandom);
        endcase
      end
    end
    wait_cycles(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
